vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
Transaction controller for the coin-operated vending path. Accepts coins over a valid/ready handshake and accumulates credit in 5-unit steps. Services a two-product selection, then sequences the dispense mechanism and the change-return hopper through req/ack handshakes. Handles cancel and inactivity timeout by refunding credit.

Parameters:
CREDIT_W, 4, width of the credit register (counted in 5-unit steps)
MAX_CREDIT, 12, maximum credit held, in 5-unit steps (60)
PRICE_A, 3, price of product 0, in 5-unit steps (15)
PRICE_B, 4, price of product 1, in 5-unit steps (20)
TIMEOUT, 255, idle cycles in CREDIT before auto-refund

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
coin_valid  in  1  coin present
coin_val  in  2  coin code: 01=5, 10=10, 00/11=invalid
coin_ready  out  1  coin accepted this cycle when coin_valid is also high
sel_valid  in  1  product selection strobe
sel_id  in  1  0=product A, 1=product B
cancel  in  1  refund request
sel_err  out  1  1-cycle pulse: selection with insufficient credit
coin_rej  out  1  1-cycle pulse: invalid coin code consumed
disp_req  out  1  dispense request, level
disp_id  out  1  product to dispense, stable while disp_req is high
disp_ack  in  1  dispenser done
chg_valid  out  1  change coin request, level
chg_coin  out  2  01=5, 10=10, stable while chg_valid is high
chg_ack  in  1  hopper released the coin
credit  out  CREDIT_W  current credit, registered
busy  out  1  high in DISPENSE or CHANGE

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; credit=0; timer=0; disp_req, chg_valid, sel_err and coin_rej all 0. Reset mid-transaction discards credit; no refund is issued.
- States: IDLE (credit=0), CREDIT, DISPENSE, CHANGE. All outputs are registered except coin_ready.
- coin_ready = (state is IDLE or CREDIT) & !cancel & !sel_valid & (credit <= MAX_CREDIT-2). The worst-case coin size is used, so coin_ready does not depend on coin_val.
- Coin handshake:
  - Code 01 adds 1 and code 10 adds 2 to credit on the next edge.
  - Codes 00/11 are consumed without changing credit, and coin_rej pulses for 1 cycle.
  - IDLE moves to CREDIT on any valid credited coin.
- Priority in IDLE/CREDIT, evaluated per cycle: cancel > sel_valid > coin.
- Selection in CREDIT, with price = sel_id ? PRICE_B : PRICE_A:
  - If credit >= price: credit -= price, disp_id = sel_id, disp_req=1 from the next cycle, state goes to DISPENSE.
  - Otherwise sel_err pulses, state and credit are unchanged.
  - sel_valid in IDLE pulses sel_err.
- DISPENSE: disp_req is held until disp_ack is sampled high. On that edge disp_req drops, then state goes to CHANGE if credit > 0, else to IDLE. Minimum turnaround is 1 cycle.
- CHANGE:
  - chg_valid=1, with chg_coin = 10 if credit >= 2, else 01.
  - On chg_ack, credit is reduced by 2 or 1 respectively, and chg_coin is recomputed for the next cycle.
  - When credit reaches 0, chg_valid drops and state goes to IDLE. Back-to-back acks drain 1 coin per cycle.
- Cancel in CREDIT goes to CHANGE. Cancel in IDLE, DISPENSE or CHANGE is ignored.
- Timeout:
  - The timer counts cycles in CREDIT and clears on any accepted coin, any selection attempt, and on leaving CREDIT.
  - When timer == TIMEOUT-1 and no other event occurs, state goes to CHANGE.
- Stray inputs: disp_ack outside DISPENSE and chg_ack while chg_valid=0 are ignored.
- Credit never exceeds MAX_CREDIT and never underflows. Arithmetic is unsigned, CREDIT_W bits.

Test Plan:
- Coins 10,10 (credit 4), sel_id=0 -> disp_req=1 with disp_id=0, credit=1. disp_ack -> CHANGE with chg_coin=01. chg_ack -> credit=0, IDLE, busy=0.
- Coin 5 (credit 1), sel_id=1 -> sel_err 1-cycle pulse, state CREDIT, credit=1, disp_req=0.
- Coins to credit 5, cancel -> chg_coin sequence 10,10,01 with acks on consecutive cycles -> credit 0, IDLE after the third ack.
- Credit 11 with coin_valid held high -> coin_ready=0 and credit stays 11. coin_val=11 at credit 0 -> coin_rej pulse, stays IDLE.
- Coin 10, then no activity for 255 cycles -> CHANGE with chg_coin=10. Ack -> IDLE. Repeat with a coin inserted at cycle 200 -> timer restarts.
- In CHANGE with credit 3, assert reset -> next cycle chg_valid=0, credit=0, IDLE. Simultaneous sel_valid+coin_valid -> coin_ready=0 and only the selection is processed.

Source files
------------

// File: rtl/vend_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller_if
// Brief    : Coin, selection, dispense and change handshakes of the vending path
// Revision : 1.0 - initial release
// ============================================================================
interface vend_controller_if #(
    parameter int CREDIT_W = 4
) ();
    logic                coin_valid;
    logic [1:0]          coin_val;
    logic                coin_ready;
    logic                sel_valid;
    logic                sel_id;
    logic                cancel;
    logic                sel_err;
    logic                coin_rej;
    logic                disp_req;
    logic                disp_id;
    logic                disp_ack;
    logic                chg_valid;
    logic [1:0]          chg_coin;
    logic                chg_ack;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_id, cancel, disp_ack, chg_ack,
        output coin_ready, sel_err, coin_rej, disp_req, disp_id, chg_valid, chg_coin,
               credit, busy
    );

    modport master (
        output coin_valid, coin_val, sel_valid, sel_id, cancel, disp_ack, chg_ack,
        input  coin_ready, sel_err, coin_rej, disp_req, disp_id, chg_valid, chg_coin,
               credit, busy
    );
endinterface
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller
// Brief    : Coin credit, product selection, dispense and change-return sequencer
// Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 12,
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 4,
    parameter int TIMEOUT    = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,
    vend_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    localparam int                  TMR_W      = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] c_one      = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] c_two      = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] c_max_coin = CREDIT_W'(MAX_CREDIT - 2);
    localparam logic [CREDIT_W-1:0] c_price_a  = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] c_price_b  = CREDIT_W'(PRICE_B);
    localparam logic [TMR_W-1:0]    c_tmo_last = TMR_W'(TIMEOUT - 1);

    state_t              r_state,     w_state_nxt;
    logic [CREDIT_W-1:0] r_credit,    w_credit_nxt;
    logic [TMR_W-1:0]    r_timer,     w_timer_nxt;
    logic                r_disp_id,   w_disp_id_nxt;
    logic                r_disp_req,  w_disp_req_nxt;
    logic                r_chg_valid, w_chg_valid_nxt;
    logic [1:0]          r_chg_coin,  w_chg_coin_nxt;
    logic                r_sel_err,   w_sel_err_nxt;
    logic                r_coin_rej,  w_coin_rej_nxt;
    logic                r_busy,      w_busy_nxt;

    logic                w_coin_ready;
    logic                w_coin_take;
    logic [CREDIT_W-1:0] w_coin_add;
    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W-1:0] w_chg_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_credit    <= '0;
            r_timer     <= '0;
            r_disp_id   <= 1'b0;
            r_disp_req  <= 1'b0;
            r_chg_valid <= 1'b0;
            r_chg_coin  <= 2'b00;
            r_sel_err   <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_credit    <= w_credit_nxt;
            r_timer     <= w_timer_nxt;
            r_disp_id   <= w_disp_id_nxt;
            r_disp_req  <= w_disp_req_nxt;
            r_chg_valid <= w_chg_valid_nxt;
            r_chg_coin  <= w_chg_coin_nxt;
            r_sel_err   <= w_sel_err_nxt;
            r_coin_rej  <= w_coin_rej_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        // Readiness assumes the largest coin so it never depends on coin_val.
        w_coin_ready = ((r_state == ST_IDLE) || (r_state == ST_CREDIT)) &&
                       !bus.cancel && !bus.sel_valid && (r_credit <= c_max_coin);
        w_coin_take  = bus.coin_valid && w_coin_ready;
        w_coin_add   = (bus.coin_val == 2'b01) ? c_one :
                       (bus.coin_val == 2'b10) ? c_two : '0;
        w_price      = bus.sel_id ? c_price_b : c_price_a;
        w_chg_dec    = (r_chg_coin == 2'b10) ? c_two : c_one;

        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_timer_nxt    = '0;
        w_disp_id_nxt  = r_disp_id;
        w_sel_err_nxt  = 1'b0;
        w_coin_rej_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.cancel) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.sel_valid) begin
                    w_sel_err_nxt = 1'b1;
                end else if (w_coin_take) begin
                    if (w_coin_add != '0) begin
                        w_credit_nxt = r_credit + w_coin_add;
                        w_state_nxt  = ST_CREDIT;
                    end else begin
                        w_coin_rej_nxt = 1'b1;
                    end
                end
            end
            ST_CREDIT: begin
                if (bus.cancel) begin
                    w_state_nxt = ST_CHANGE;
                end else if (bus.sel_valid) begin
                    if (r_credit >= w_price) begin
                        w_credit_nxt  = r_credit - w_price;
                        w_disp_id_nxt = bus.sel_id;
                        w_state_nxt   = ST_DISPENSE;
                    end else begin
                        w_sel_err_nxt = 1'b1;
                    end
                end else if (w_coin_take) begin
                    w_credit_nxt   = r_credit + w_coin_add;
                    w_coin_rej_nxt = (w_coin_add == '0);
                end else if (r_timer == c_tmo_last) begin
                    w_state_nxt = ST_CHANGE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_DISPENSE: begin
                if (bus.disp_ack) begin
                    w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (r_chg_valid && bus.chg_ack) begin
                    w_credit_nxt = r_credit - w_chg_dec;
                    if (w_credit_nxt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Handshake levels follow the next state so they rise with state entry.
        w_disp_req_nxt  = (w_state_nxt == ST_DISPENSE);
        w_chg_valid_nxt = (w_state_nxt == ST_CHANGE);
        w_chg_coin_nxt  = !w_chg_valid_nxt         ? 2'b00 :
                          (w_credit_nxt >= c_two)  ? 2'b10 : 2'b01;
        w_busy_nxt      = (w_state_nxt == ST_DISPENSE) || (w_state_nxt == ST_CHANGE);
    end

    assign bus.coin_ready = w_coin_ready;
    assign bus.sel_err    = r_sel_err;
    assign bus.coin_rej   = r_coin_rej;
    assign bus.disp_req   = r_disp_req;
    assign bus.disp_id    = r_disp_id;
    assign bus.chg_valid  = r_chg_valid;
    assign bus.chg_coin   = r_chg_coin;
    assign bus.credit     = r_credit;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_controller
// Brief    : Randomized scoreboard bench for vend_controller
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

    localparam int CREDIT_W   = 4;
    localparam int MAX_CREDIT = 12;
    localparam int PRICE_A    = 3;
    localparam int PRICE_B    = 4;
    localparam int TIMEOUT    = 255;

    localparam int EV_ERR  = 1;
    localparam int EV_REJ  = 2;
    localparam int EV_DISP = 3;
    localparam int EV_CHG  = 4;

    logic clk = 1'b0;
    logic reset;

    vend_controller_if #(.CREDIT_W(CREDIT_W)) bus ();

    vend_controller #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT),
        .PRICE_A    (PRICE_A),
        .PRICE_B    (PRICE_B),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int m_credit = 0;
    bit ack_en   = 1'b1;
    bit ack_all  = 1'b0;

    function automatic int ev(int kind, int val);
        return kind * 4 + val;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Refund is paid greedily in 10-unit coins, then a final 5 if odd.
    task automatic push_refund(int c);
        while (c > 0) begin
            if (c >= 2) begin
                exp_q.push_back(ev(EV_CHG, 2));
                c -= 2;
            end else begin
                exp_q.push_back(ev(EV_CHG, 1));
                c -= 1;
            end
        end
    endtask

    task automatic observe(int obs);
        int e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got %0d expected none (t=%0t)", obs, $time);
        end else begin
            e = exp_q.pop_front();
            check("event", obs, e);
        end
    endtask

    // Monitor: decoded output events are matched against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (bus.sel_err)                observe(ev(EV_ERR, 0));
                if (bus.coin_rej)               observe(ev(EV_REJ, 0));
                if (bus.disp_req && bus.disp_ack)  observe(ev(EV_DISP, int'(bus.disp_id)));
                if (bus.chg_valid && bus.chg_ack)  observe(ev(EV_CHG, int'(bus.chg_coin)));
            end
        end
    end

    // Dispenser/hopper responder, including stray acks while idle.
    initial begin
        bus.disp_ack = 1'b0;
        bus.chg_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && bus.disp_req) bus.disp_ack = ($urandom % 3 == 0);
            else                        bus.disp_ack = !bus.disp_req && ($urandom % 16 == 0);
            if (ack_en && bus.chg_valid) bus.chg_ack = ack_all ? 1'b1 : ($urandom % 2 == 0);
            else if (ack_all)            bus.chg_ack = 1'b0;
            else                         bus.chg_ack = !bus.chg_valid && ($urandom % 16 == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_idle(output int cycles);
        int k = 0;
        while ((bus.busy || bus.disp_req || bus.chg_valid) && k < 200) begin
            @(negedge clk);
            k++;
        end
        cycles = k;
        check("idle_reached", int'(k < 200), 1);
        check("credit_after_idle", int'(bus.credit), m_credit);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic drive_coin(int code);
        int exp_ready;
        bus.coin_valid = 1'b1;
        bus.coin_val   = code[1:0];
        #1;
        exp_ready = (m_credit <= MAX_CREDIT - 2) ? 1 : 0;
        check("coin_ready", int'(bus.coin_ready), exp_ready);
        if (exp_ready == 1) begin
            if (code == 1 || code == 2) m_credit += code;
            else                        exp_q.push_back(ev(EV_REJ, 0));
        end
        @(negedge clk);
        bus.coin_valid = 1'b0;
        bus.coin_val   = 2'b00;
        check("credit_after_coin", int'(bus.credit), m_credit);
    endtask

    task automatic drive_sel(int id, bit with_coin);
        int price = (id != 0) ? PRICE_B : PRICE_A;
        int cyc;
        bit go = 1'b0;
        bus.sel_valid = 1'b1;
        bus.sel_id    = id[0];
        if (with_coin) begin
            bus.coin_valid = 1'b1;
            bus.coin_val   = 2'b10;
        end
        #1;
        if (with_coin) check("coin_ready_vs_sel", int'(bus.coin_ready), 0);
        if (m_credit == 0 || m_credit < price) begin
            exp_q.push_back(ev(EV_ERR, 0));
        end else begin
            go = 1'b1;
            exp_q.push_back(ev(EV_DISP, id));
            m_credit -= price;
        end
        @(negedge clk);
        bus.sel_valid  = 1'b0;
        bus.coin_valid = 1'b0;
        bus.coin_val   = 2'b00;
        check("credit_after_sel", int'(bus.credit), m_credit);
        check("disp_req_after_sel", int'(bus.disp_req), int'(go));
        if (go) begin
            check("disp_id", int'(bus.disp_id), id);
            push_refund(m_credit);
            m_credit = 0;
            wait_idle(cyc);
        end
    endtask

    task automatic drive_cancel(output int cyc);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        cyc = 0;
        if (m_credit > 0) begin
            check("chg_valid_after_cancel", int'(bus.chg_valid), 1);
            push_refund(m_credit);
            m_credit = 0;
            wait_idle(cyc);
        end else begin
            check("busy_after_idle_cancel", int'(bus.busy), 0);
        end
    endtask

    initial begin
        int cyc;
        bit last_blocked = 1'b0;
        reset          = 1'b1;
        bus.coin_valid = 1'b0;
        bus.coin_val   = 2'b00;
        bus.sel_valid  = 1'b0;
        bus.sel_id     = 1'b0;
        bus.cancel     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_credit",    int'(bus.credit),    0);
        check("rst_disp_req",  int'(bus.disp_req),  0);
        check("rst_chg_valid", int'(bus.chg_valid), 0);
        check("rst_busy",      int'(bus.busy),      0);
        check("rst_sel_err",   int'(bus.sel_err),   0);
        check("rst_coin_rej",  int'(bus.coin_rej),  0);
        reset = 1'b0;
        @(negedge clk);

        // Buy A with 20 units, 5 returned.
        drive_coin(2); drive_coin(2);
        drive_sel(0, 1'b0);

        // Insufficient credit for B.
        drive_coin(1);
        drive_sel(1, 1'b0);
        check("state_credit_kept", int'(bus.busy), 0);
        drive_cancel(cyc);

        // Back-to-back change drain of 25 units.
        ack_all = 1'b1;
        drive_coin(2); drive_coin(2); drive_coin(1);
        drive_cancel(cyc);
        check("drain_cycles", cyc, 3);
        ack_all = 1'b0;

        // Credit 11 blocks further coins.
        repeat (5) drive_coin(2);
        drive_coin(1);
        bus.coin_valid = 1'b1;
        bus.coin_val   = 2'b10;
        repeat (3) begin
            #1;
            check("coin_ready_full", int'(bus.coin_ready), 0);
            @(negedge clk);
            check("credit_full", int'(bus.credit), 11);
        end
        bus.coin_valid = 1'b0;
        drive_cancel(cyc);

        // Invalid coin in IDLE, then selection with no credit.
        drive_coin(3);
        check("busy_after_rej", int'(bus.busy), 0);
        drive_sel(0, 1'b0);

        // Inactivity timeout.
        drive_coin(2);
        repeat (254) @(negedge clk);
        check("tmo_not_yet", int'(bus.chg_valid), 0);
        push_refund(m_credit);
        m_credit = 0;
        @(negedge clk);
        check("tmo_fired", int'(bus.chg_valid), 1);
        check("tmo_chg_coin", int'(bus.chg_coin), 2);
        wait_idle(cyc);

        // A coin at cycle 200 restarts the timer.
        drive_coin(1);
        repeat (199) @(negedge clk);
        drive_coin(1);
        repeat (254) @(negedge clk);
        check("tmo2_not_yet", int'(bus.chg_valid), 0);
        push_refund(m_credit);
        m_credit = 0;
        @(negedge clk);
        check("tmo2_fired", int'(bus.chg_valid), 1);
        check("tmo2_chg_coin", int'(bus.chg_coin), 2);
        wait_idle(cyc);

        // Reset while in CHANGE discards credit without refund.
        ack_en = 1'b0;
        drive_coin(2); drive_coin(1);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("pre_rst_chg_valid", int'(bus.chg_valid), 1);
        check("pre_rst_credit",    int'(bus.credit),    3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_credit = 0;
        check("mid_rst_chg_valid", int'(bus.chg_valid), 0);
        check("mid_rst_credit",    int'(bus.credit),    0);
        check("mid_rst_busy",      int'(bus.busy),      0);
        ack_en = 1'b1;

        // Simultaneous selection and coin: only the selection is taken.
        drive_coin(2); drive_coin(2);
        drive_sel(0, 1'b1);

        // Randomized transactions.
        for (int i = 0; i < 400; i++) begin
            int r = $urandom % 100;
            if (m_credit > MAX_CREDIT - 2 && last_blocked) r = 50 + ($urandom % 50);
            if (r < 45) begin
                int code = ($urandom % 8 == 0) ? (($urandom % 2 == 0) ? 0 : 3)
                                               : 1 + ($urandom % 2);
                last_blocked = (m_credit > MAX_CREDIT - 2);
                drive_coin(code);
            end else if (r < 85) begin
                last_blocked = 1'b0;
                drive_sel(int'($urandom % 2), ($urandom % 4 == 0));
            end else if (r < 92) begin
                last_blocked = 1'b0;
                drive_cancel(cyc);
            end else begin
                repeat (1 + $urandom % 4) @(negedge clk);
            end
        end
        drive_cancel(cyc);
        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
